// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter
//   Bus-ownership controller and transaction scheduler for the 68000 cycle
//   engine. Pi-side ops are queued and handed to the engine one at a time
//   while the PiStorm owns the bus. The block also runs the BR/BG/BGACK
//   handshake so Amiga DMA masters can take the bus between cycles.
//
// Ports
//   c200m, reset              system clock, synchronous active-high reset
//   c7m_rising, c7m_falling   single-cycle c7m edge strobes
//   br_n, bgack_n             raw asynchronous M68K_BR_n / M68K_BGACK_n
//   push, push_rw,
//   push_uds_n, push_lds_n    enqueue strobe and op fields
//   engine_busy               cycle engine cannot accept an op
//   issue, issue_rw,
//   issue_uds_n, issue_lds_n  one-cycle hand-off of the queue head
//   bg_n                      M68K_BG_n drive
//   bus_owned                 PiStorm currently owns the bus
//   q_full                    queue holds QDEPTH ops
//   txn_pending               work outstanding or bus not owned
//   overflow                  sticky: a push was dropped on a full queue

module m68k_bus_arbiter #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic c200m,
  input  logic reset,
  input  logic c7m_rising,
  input  logic c7m_falling,
  input  logic br_n,
  input  logic bgack_n,
  input  logic push,
  input  logic push_rw,
  input  logic push_uds_n,
  input  logic push_lds_n,
  input  logic engine_busy,
  output logic issue,
  output logic issue_rw,
  output logic issue_uds_n,
  output logic issue_lds_n,
  output logic bg_n,
  output logic bus_owned,
  output logic q_full,
  output logic txn_pending,
  output logic overflow
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic rw;
    logic uds_n;
    logic lds_n;
  } op_t;

  typedef enum logic [2:0] {
    S_OWN,
    S_DRAIN,
    S_GRANT,
    S_EXT,
    S_RECLAIM
  } state_t;

  state_t           state;
  logic             br_meta, br_sync, br_s;
  logic             bgack_meta, bgack_sync, bgack_s;
  logic             issue_hold;
  logic             reclaim_armed;
  op_t              issue_op;
  op_t              push_op;
  op_t              mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             can_issue;
  logic             do_push;

  assign push_op = {push_rw, push_uds_n, push_lds_n};

  // Head may go out only in OWN with BR idle; issue/issue_hold give the engine
  // two cycles to raise engine_busy before the next hand-off is considered.
  assign can_issue = (state == S_OWN) && br_s && (count != '0) &&
                     !engine_busy && !issue && !issue_hold;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!q_full || can_issue);

  always_comb begin
    count_next = count;
    if (do_push && !can_issue) begin
      count_next = count + CNT_W'(1);
    end else if (can_issue && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  assign issue_rw    = issue_op.rw;
  assign issue_uds_n = issue_op.uds_n;
  assign issue_lds_n = issue_op.lds_n;
  assign txn_pending = (count != '0) || engine_busy || !bus_owned;

  // BR/BGACK synchronizers; the sampled copies move only on c7m rising edges.
  always_ff @(posedge c200m) begin
    if (reset) begin
      br_meta    <= 1'b1;
      br_sync    <= 1'b1;
      br_s       <= 1'b1;
      bgack_meta <= 1'b1;
      bgack_sync <= 1'b1;
      bgack_s    <= 1'b1;
    end else begin
      br_meta    <= br_n;
      br_sync    <= br_meta;
      bgack_meta <= bgack_n;
      bgack_sync <= bgack_meta;
      if (c7m_rising) begin
        br_s    <= br_sync;
        bgack_s <= bgack_sync;
      end
    end
  end

  // Op queue pointers, occupancy and overflow flag.
  always_ff @(posedge c200m) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      q_full   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (can_issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count  <= count_next;
      q_full <= (count_next == CNT_W'(QDEPTH));
      if (push && q_full && !can_issue) begin
        overflow <= 1'b1;
      end
    end
  end

  // Queue storage; contents are meaningless while count says empty.
  always_ff @(posedge c200m) begin
    if (do_push) begin
      mem[wr_ptr] <= push_op;
    end
  end

  // Ownership FSM with registered bg_n / bus_owned / issue outputs.
  always_ff @(posedge c200m) begin
    if (reset) begin
      state         <= S_OWN;
      bg_n          <= 1'b1;
      bus_owned     <= 1'b1;
      issue         <= 1'b0;
      issue_hold    <= 1'b0;
      issue_op      <= 3'b111;
      reclaim_armed <= 1'b0;
    end else begin
      issue      <= can_issue;
      issue_hold <= issue;
      if (can_issue) begin
        issue_op <= mem[rd_ptr];
      end

      case (state)
        S_OWN: begin
          if (!br_s) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (br_s) begin
            state <= S_OWN;
          end else if (c7m_falling && !engine_busy) begin
            bg_n      <= 1'b0;
            bus_owned <= 1'b0;
            state     <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (!bgack_s) begin
            state <= S_EXT;
          end else if (br_s && c7m_falling) begin
            // Request withdrawn before any master acknowledged.
            bg_n          <= 1'b1;
            reclaim_armed <= 1'b0;
            state         <= S_RECLAIM;
          end
        end

        S_EXT: begin
          // Grant is released on the first falling edge; a new BR here
          // waits until the bus has been reclaimed.
          if (c7m_falling) begin
            bg_n <= 1'b1;
          end
          if (bgack_s) begin
            reclaim_armed <= 1'b0;
            state         <= S_RECLAIM;
          end
        end

        S_RECLAIM: begin
          if (c7m_falling) begin
            bg_n <= 1'b1;
          end
          // First rising edge arms, the next one closes the full c7m period.
          if (c7m_rising) begin
            if (reclaim_armed) begin
              bus_owned <= 1'b1;
              state     <= br_s ? S_OWN : S_DRAIN;
            end else begin
              reclaim_armed <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_OWN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// tb_m68k_bus_arbiter
//   Directed scenarios plus a randomized soak. A behavioural model of bus
//   ownership (phases + op queue) predicts every output each cycle; a few
//   literal expectations pin the model to the intended behaviour.

module tb_m68k_bus_arbiter;

  localparam int unsigned QDEPTH = 2;
  localparam int C7_PER = 8;

  localparam int PH_OWN     = 0;
  localparam int PH_DRAIN   = 1;
  localparam int PH_GRANT   = 2;
  localparam int PH_EXT     = 3;
  localparam int PH_RECLAIM = 4;

  logic c200m = 1'b0;
  logic reset = 1'b1;
  logic c7m_rising = 1'b0, c7m_falling = 1'b0;
  logic br_n = 1'b1, bgack_n = 1'b1;
  logic push = 1'b0, push_rw = 1'b1, push_uds_n = 1'b1, push_lds_n = 1'b1;
  logic engine_busy = 1'b0;
  logic issue, issue_rw, issue_uds_n, issue_lds_n;
  logic bg_n, bus_owned, q_full, txn_pending, overflow;

  m68k_bus_arbiter #(.QDEPTH(QDEPTH)) dut (
    .c200m       (c200m),
    .reset       (reset),
    .c7m_rising  (c7m_rising),
    .c7m_falling (c7m_falling),
    .br_n        (br_n),
    .bgack_n     (bgack_n),
    .push        (push),
    .push_rw     (push_rw),
    .push_uds_n  (push_uds_n),
    .push_lds_n  (push_lds_n),
    .engine_busy (engine_busy),
    .issue       (issue),
    .issue_rw    (issue_rw),
    .issue_uds_n (issue_uds_n),
    .issue_lds_n (issue_lds_n),
    .bg_n        (bg_n),
    .bus_owned   (bus_owned),
    .q_full      (q_full),
    .txn_pending (txn_pending),
    .overflow    (overflow)
  );

  always #5 c200m = ~c200m;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- environment: c7m strobes and engine ----------------
  int c7m_ph    = 0;
  int busy_left = 0;
  int eng_len   = 40;
  bit hold_busy = 1'b0;

  always @(negedge c200m) begin
    #1;
    c7m_ph      = (c7m_ph + 1) % C7_PER;
    c7m_rising  = (c7m_ph == 0);
    c7m_falling = (c7m_ph == C7_PER / 2);
    if (reset)           busy_left = 0;
    else if (issue)      busy_left = eng_len;
    else if (busy_left > 0) busy_left--;
    engine_busy = hold_busy || (busy_left > 0);
  end

  // ---------------- behavioural model ----------------
  bit       m_br_p1 = 1, m_br_p2 = 1, m_br_s = 1;
  bit       m_bg_p1 = 1, m_bg_p2 = 1, m_bg_s = 1;
  bit [2:0] mq[$];
  bit       m_issue  = 0;
  bit [2:0] m_fields = 3'b111;
  int       last_issue = -100;
  int       phase    = PH_OWN;
  int       rises    = 0;
  bit       m_bg_n   = 1;
  bit       m_owned  = 1;
  bit       m_ovf    = 0;

  always @(posedge c200m) begin
    bit elig;
    cyc++;
    if (reset) begin
      m_br_p1 = 1; m_br_p2 = 1; m_br_s = 1;
      m_bg_p1 = 1; m_bg_p2 = 1; m_bg_s = 1;
      mq.delete();
      m_issue = 0; m_fields = 3'b111; last_issue = -100;
      phase = PH_OWN; rises = 0;
      m_bg_n = 1; m_owned = 1; m_ovf = 0;
    end else begin
      // Hand-off allowed at most once every three edges, only in ownership.
      elig = (phase == PH_OWN) && m_br_s && (mq.size() > 0) &&
             !engine_busy && ((cyc - last_issue) >= 3);
      m_issue = elig;
      if (elig) begin
        m_fields   = mq.pop_front();
        last_issue = cyc;
      end
      if (push) begin
        if (mq.size() < QDEPTH) mq.push_back({push_rw, push_uds_n, push_lds_n});
        else m_ovf = 1;
      end

      case (phase)
        PH_OWN: if (!m_br_s) phase = PH_DRAIN;
        PH_DRAIN: begin
          if (m_br_s) phase = PH_OWN;
          else if (c7m_falling && !engine_busy) begin
            phase = PH_GRANT; m_bg_n = 0; m_owned = 0;
          end
        end
        PH_GRANT: begin
          if (!m_bg_s) phase = PH_EXT;
          else if (m_br_s && c7m_falling) begin
            m_bg_n = 1; phase = PH_RECLAIM; rises = 0;
          end
        end
        PH_EXT: begin
          if (c7m_falling) m_bg_n = 1;
          if (m_bg_s) begin phase = PH_RECLAIM; rises = 0; end
        end
        default: begin
          if (c7m_falling) m_bg_n = 1;
          if (c7m_rising) begin
            rises++;
            if (rises == 2) begin
              m_owned = 1;
              phase = m_br_s ? PH_OWN : PH_DRAIN;
            end
          end
        end
      endcase

      if (c7m_rising) begin
        m_br_s = m_br_p2;
        m_bg_s = m_bg_p2;
      end
      m_br_p2 = m_br_p1; m_br_p1 = br_n;
      m_bg_p2 = m_bg_p1; m_bg_p1 = bgack_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  int       n_issue = 0;
  bit [2:0] ops_log[$];
  int       issue_cyc[$];

  always @(negedge c200m) begin
    if (chk_en) begin
      chk("issue", 8'(issue), 8'(m_issue));
      if (m_issue) chk("issue_op", 8'({issue_rw, issue_uds_n, issue_lds_n}), 8'(m_fields));
      chk("bg_n", 8'(bg_n), 8'(m_bg_n));
      chk("bus_owned", 8'(bus_owned), 8'(m_owned));
      chk("q_full", 8'(q_full), 8'(mq.size() == QDEPTH));
      chk("overflow", 8'(overflow), 8'(m_ovf));
      chk("txn_pending", 8'(txn_pending),
          8'((mq.size() != 0) || engine_busy || !m_owned));
      if (issue === 1'b1) begin
        n_issue++;
        ops_log.push_back({issue_rw, issue_uds_n, issue_lds_n});
        issue_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge c200m);
    #2;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return bg_n;
      1:       return bus_owned;
      2:       return issue;
      default: return txn_pending;
    endcase
  endfunction

  task automatic wait_until(input string nm, input int w, input logic v, input int budget);
    int n = 0;
    while (sel(w) !== v && n < budget) begin
      step();
      n++;
    end
    total++;
    if (sel(w) !== v) begin
      bad++;
      $display("FAIL wait_%s: value %0b after %0d cycles, required %0b", nm, sel(w), budget, v);
    end
  endtask

  task automatic do_push(input logic [2:0] op);
    push = 1'b1;
    {push_rw, push_uds_n, push_lds_n} = op;
    step();
    push = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int b1;
    int n;

    reset = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    reset = 1'b0;

    // Reset state literals.
    chk("rst_bg_n", 8'(bg_n), 8'd1);
    chk("rst_bus_owned", 8'(bus_owned), 8'd1);
    chk("rst_issue", 8'(issue), 8'd0);
    chk("rst_fields", 8'({issue_rw, issue_uds_n, issue_lds_n}), 8'h7);
    chk("rst_q_full", 8'(q_full), 8'd0);
    chk("rst_overflow", 8'(overflow), 8'd0);
    chk("rst_txn_pending", 8'(txn_pending), 8'(engine_busy));
    repeat (4) step();

    // Two ops, engine busy 40 cycles each: FIFO order, >= 40 cycles apart.
    eng_len = 40;
    b1 = ops_log.size();
    do_push(3'b101);
    do_push(3'b010);
    n = 0;
    while (ops_log.size() < b1 + 2 && n < 200) begin step(); n++; end
    chk("t1_issue_count", 8'(ops_log.size() - b1), 8'd2);
    if (ops_log.size() >= b1 + 2) begin
      chk("t1_first_op", 8'(ops_log[b1]), 8'h5);
      chk("t1_second_op", 8'(ops_log[b1+1]), 8'h2);
      chk("t1_gap_ge_40", 8'((issue_cyc[b1+1] - issue_cyc[b1]) >= 40), 8'd1);
    end
    wait_until("t1_txn_idle", 3, 1'b0, 100);

    // Three pushes into a held engine: full after two, overflow on the third.
    hold_busy = 1'b1;
    repeat (2) step();
    base = n_issue;
    do_push(3'b001);
    push = 1'b1; {push_rw, push_uds_n, push_lds_n} = 3'b011; step();
    chk("t2_q_full", 8'(q_full), 8'd1);
    chk("t2_no_overflow_yet", 8'(overflow), 8'd0);
    {push_rw, push_uds_n, push_lds_n} = 3'b110; step();
    push = 1'b0;
    chk("t2_overflow", 8'(overflow), 8'd1);
    eng_len = 5;
    hold_busy = 1'b0;
    repeat (60) step();
    chk("t2_two_issues", 8'(n_issue - base), 8'd2);
    chk("t2_last_op", 8'(ops_log[$]), 8'h3);
    wait_until("t2_txn_idle", 3, 1'b0, 100);

    // BR while busy with one op queued: no issue, grant after drain.
    eng_len = 30;
    do_push(3'b100);
    wait_until("t3_issue_a", 2, 1'b1, 10);
    step();
    do_push(3'b111);
    base = n_issue;
    br_n = 1'b0;
    wait_until("t3_bg_low", 0, 1'b0, 200);
    chk("t3_no_issue", 8'(n_issue - base), 8'd0);
    bgack_n = 1'b0;
    repeat (3) step();
    br_n = 1'b1;
    wait_until("t3_bg_release", 0, 1'b1, 40);
    chk("t3_ext_not_owned", 8'(bus_owned), 8'd0);
    repeat (10) step();
    bgack_n = 1'b1;
    wait_until("t3_issue_b", 2, 1'b1, 60);
    chk("t3_one_issue", 8'(n_issue - base), 8'd1);
    chk("t3_op_b", 8'(ops_log[$]), 8'h7);
    wait_until("t3_txn_idle", 3, 1'b0, 100);

    // BR pulse withdrawn before BGACK: grant, release, reclaim, then issue.
    base = n_issue;
    br_n = 1'b0;
    wait_until("t4_bg_low", 0, 1'b0, 60);
    do_push(3'b110);
    br_n = 1'b1;
    wait_until("t4_bg_release", 0, 1'b1, 60);
    chk("t4_reclaim_not_owned", 8'(bus_owned), 8'd0);
    chk("t4_no_issue", 8'(n_issue - base), 8'd0);
    wait_until("t4_owned", 1, 1'b1, 60);
    wait_until("t4_issue", 2, 1'b1, 10);
    chk("t4_op", 8'(ops_log[$]), 8'h6);
    wait_until("t4_txn_idle", 3, 1'b0, 100);

    // BR sample lands in the same cycle the pushed op becomes eligible.
    base = n_issue;
    n = 0;
    while (!c7m_rising && n < 16) begin step(); n++; end
    br_n = 1'b0;
    repeat (C7_PER) step();
    do_push(3'b000);
    repeat (3) step();
    chk("t5_br_wins", 8'(n_issue - base), 8'd0);
    wait_until("t5_bg_low", 0, 1'b0, 60);
    bgack_n = 1'b0;
    repeat (2) step();
    br_n = 1'b1;
    repeat (6) step();
    bgack_n = 1'b1;
    wait_until("t5_issue", 2, 1'b1, 60);
    chk("t5_one_issue", 8'(n_issue - base), 8'd1);
    chk("t5_op", 8'(ops_log[$]), 8'h0);
    wait_until("t5_txn_idle", 3, 1'b0, 100);

    // Reset while an external master holds the bus.
    br_n = 1'b0;
    wait_until("t6_bg_low", 0, 1'b0, 60);
    bgack_n = 1'b0;
    repeat (12) step();
    do_push(3'b101);
    chk("t6_overflow_sticky", 8'(overflow), 8'd1);
    base = n_issue;
    reset = 1'b1;
    br_n = 1'b1;
    bgack_n = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_bg_n", 8'(bg_n), 8'd1);
    chk("t6_owned", 8'(bus_owned), 8'd1);
    chk("t6_q_full", 8'(q_full), 8'd0);
    chk("t6_overflow", 8'(overflow), 8'd0);
    chk("t6_txn_pending", 8'(txn_pending), 8'(engine_busy));
    repeat (20) step();
    chk("t6_queue_dropped", 8'(n_issue - base), 8'd0);

    // Randomized soak against the model.
    for (int i = 0; i < 4000; i++) begin
      push       = ($urandom_range(0, 99) < 20);
      push_rw    = 1'($urandom);
      push_uds_n = 1'($urandom);
      push_lds_n = 1'($urandom);
      if ($urandom_range(0, 99) < 3) br_n = ~br_n;
      if (bg_n === 1'b0 && $urandom_range(0, 9) == 0) bgack_n = 1'b0;
      else if (bgack_n == 1'b0 && $urandom_range(0, 29) == 0) bgack_n = 1'b1;
      if (bgack_n == 1'b0 && $urandom_range(0, 9) == 0) br_n = 1'b1;
      if ($urandom_range(0, 49) == 0) eng_len = $urandom_range(1, 25);
      if ($urandom_range(0, 99) == 0) hold_busy = ~hold_busy;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    push = 1'b0;
    reset = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
